// File: rtl/lsu_handshake.sv
// lsu_handshake: multi-cycle RV32 load/store unit.
//
// Accepts one load or store from the core, drives a word-wide data bus and
// returns the formatted result. Store data is replicated across byte lanes
// and given byte strobes. Load data is taken from the addressed lane and
// sign- or zero-extended. Misaligned accesses and illegal funct3 values
// complete without touching the bus. A bus response that never arrives
// ends the access with a bus error after TIMEOUT wait cycles.
//
// Handshakes (all outputs are registered):
//   core in  : an access transfers on a clock edge where in_valid && in_ready.
//              in_ready is high only while the unit is idle.
//   core out : out_valid and the result stay stable until a clock edge where
//              out_valid && out_ready. The unit is then idle on the next cycle.
//   bus req  : mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stay stable
//              until a clock edge where mem_req && mem_gnt.
//   bus resp : mem_rvalid is looked at only while waiting for a response.
//              At any other time it is ignored.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    core request handshake
//   in_store, in_funct3  access kind (store flag, RV32 funct3)
//   in_addr, in_wdata    byte address, store source data
//   out_valid/out_ready  result handshake
//   out_data             load result (0 for stores and exceptions)
//   out_misal            misaligned or illegal access, no bus access made
//   out_buserr           no mem_rvalid within TIMEOUT wait cycles
//   mem_req/mem_gnt      bus request handshake
//   mem_we, mem_addr     write flag, word-aligned address
//   mem_wdata, mem_wstrb lane-replicated store data, byte enables
//   mem_rvalid, mem_rdata bus response and read word
module lsu_handshake #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_misal,
    output logic              out_buserr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    // The counter only has to reach TIMEOUT-1. TIMEOUT of 0 or 1 still
    // needs a 1-bit counter.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_misal_q, out_misal_d;
    logic              out_buserr_q, out_buserr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Decoding of the access being offered.
    logic              acc_bad;
    logic [3:0]        st_strb;
    logic [31:0]       st_wdata;

    // Formatting of the returned read word.
    logic [31:0]       rd_shift;
    logic [31:0]       load_val;

    always_comb begin
        acc_bad  = 1'b0;
        st_strb  = 4'b1111;
        st_wdata = in_wdata;
        case (in_funct3)
            3'b000:  acc_bad = 1'b0;
            3'b001:  acc_bad = in_addr[0];
            3'b010:  acc_bad = |in_addr[1:0];
            3'b100:  acc_bad = in_store;               // no unsigned stores
            3'b101:  acc_bad = in_store | in_addr[0];
            default: acc_bad = 1'b1;
        endcase
        case (in_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << in_addr[1:0];
                st_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << in_addr[1:0];
                st_wdata = {2{in_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = in_wdata;
            end
        endcase
    end

    always_comb begin
        // Move the addressed lane down to bit 0. Then extend it.
        rd_shift = mem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {24'h000000, rd_shift[7:0]};
            3'b101:  load_val = {16'h0000, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_misal_d  = out_misal_q;
        out_buserr_d = out_buserr_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    store_d    = in_store;
                    funct3_d   = in_funct3;
                    lane_d     = in_addr[1:0];
                    if (acc_bad) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_misal_d = 1'b1;
                        out_data_d  = 32'h0;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_store;
                        mem_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = in_store ? st_wdata : 32'h0;
                        mem_wstrb_d = in_store ? st_strb : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d   = S_WAIT;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response on the expiry cycle still counts as a normal
                // completion, so rvalid is checked first.
                if (mem_rvalid) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = store_q ? 32'h0 : load_val;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d      = S_DONE;
                    out_valid_d  = 1'b1;
                    out_buserr_d = 1'b1;
                    out_data_d   = 32'h0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d      = S_IDLE;
                    in_ready_d   = 1'b1;
                    out_valid_d  = 1'b0;
                    out_misal_d  = 1'b0;
                    out_buserr_d = 1'b0;
                    out_data_d   = 32'h0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            out_misal_q  <= 1'b0;
            out_buserr_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_misal_q  <= out_misal_d;
            out_buserr_q <= out_buserr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_misal  = out_misal_q;
    assign out_buserr = out_buserr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// tb_lsu_handshake: randomized self-checking bench for lsu_handshake.
// A transaction-level model computes strobes, write data, load results and
// exception flags from the RV32 access rules. A cycle-driven bus responder
// chooses the grant delay, the response delay and the result back-pressure.
module tb_lsu_handshake;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_misal;
    logic        out_buserr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    lsu_handshake #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_misal(out_misal), .out_buserr(out_buserr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model
    function automatic bit ref_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int bytes;
        if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (!legal) return 1'b1;
        bytes = 1 << f3[1:0];
        return (a % bytes) != 0;
    endfunction

    function automatic logic [3:0] ref_strb(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        if (!st) return 4'b0000;
        bytes = 1 << f3[1:0];
        return 4'(((1 << bytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        logic [31:0] mask;
        int          w;
        v = r >> (8 * (a % 4));
        w = 8 << f3[1:0];
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        v = v & mask;
        if (!f3[2] && (w < 32) && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    // Driver for one complete access with a chosen bus and core timing.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] r,
                           input int gnt_dly, input int rv_dly, input int out_dly);
        bit          bad;
        bit          tmo;
        int          waited;
        logic [31:0] exp_data;
        bad = ref_bad(st, f3, a);
        tmo = !bad && (rv_dly >= TO);
        exp_q.push_back((bad || st || tmo) ? 32'h0 : ref_load(f3, a, r));

        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = d;
        step();
        in_valid  = 1'b0;
        in_wdata  = $urandom;

        if (bad) begin
            chk("misal_no_req", mem_req, 0);
        end else begin
            for (int g = 0; g <= gnt_dly; g++) begin
                mem_gnt = (g == gnt_dly);
                chk("req", mem_req, 1);
                chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("req_we", mem_we, st);
                chk("req_wstrb", mem_wstrb, ref_strb(st, f3, a));
                if (st) chk("req_wdata", mem_wdata, ref_wdata(f3, d));
                chk("no_out_in_req", out_valid, 0);
                step();
            end
            mem_gnt = 1'b0;
            chk("req_drop", mem_req, 0);
            waited = 0;
            while (1) begin
                chk("no_out_in_wait", out_valid, 0);
                if (waited == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = r;
                    step();
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    break;
                end
                mem_rdata = $urandom;
                step();
                waited++;
                if (waited == TO) break;
            end
        end

        exp_data = exp_q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("out_misal", out_misal, bad);
        chk("out_buserr", out_buserr, tmo);
        chk("out_data", out_data, exp_data);
        chk("in_ready_busy", in_ready, 0);
        chk("no_req_done", mem_req, 0);
        for (int h = 0; h < out_dly; h++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_clear", out_valid, 0);
        chk("misal_clear", out_misal, 0);
        chk("buserr_clear", out_buserr, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    // Stimulus and final report
    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [2:0]  f3_tab[11];
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_store   = 1'b0;
        in_funct3  = 3'b000;
        in_addr    = 32'h0;
        in_wdata   = 32'h0;
        out_ready  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_misal", out_misal, 0);
        chk("rst_buserr", out_buserr, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);

        // Directed cases
        run_txn(0, 3'b010, 32'h100, 32'h0, 32'h8000_00F1, 0, 0, 0);
        run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 0);
        run_txn(0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 1, 0);
        run_txn(1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 0, 0);
        run_txn(0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 3'b000, 32'h201, 32'h0000_00A5, 32'h0, 5, 0, 0);
        run_txn(0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 0, TO + 2, 0);
        run_txn(0, 3'b101, 32'h302, 32'h0, 32'hBEEF_0000, 0, TO - 1, 0);
        run_txn(0, 3'b001, 32'h402, 32'h0, 32'h8123_4567, 0, 0, 3);

        // Reset in WAIT followed by a stray response
        in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h500;
        step();
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt  = 1'b0;
        chk("rw_req_drop", mem_req, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_in_ready", in_ready, 1);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_req", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("stray_out_valid", out_valid, 0);
        chk("stray_in_ready", in_ready, 1);
        step();
        chk("stray_out_valid2", out_valid, 0);

        // Reset in REQ drops the request
        in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b010; in_addr = 32'h600;
        step();
        in_valid = 1'b0;
        chk("rq_req", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rq_req_drop", mem_req, 0);
        chk("rq_in_ready", in_ready, 1);

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = f3_tab[$urandom_range(0, 10)];
            run_txn(st, f3, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
